step_phase_monitor: RTL and testbench
=====================================

# step_phase_monitor

Decodes the 4-bit coil-drive pattern sent to the stepper driver back into step events. It sits on the receive side of the `pulses_out` interface, fed either by the on-chip generator's output or by an external driver loopback. Per accepted step it reports direction and step size, keeps a signed half-step position, measures the step period in `clk` cycles and flags skipped or illegal patterns. Typical use is closed-loop checking of the motor state machine and speed display cross-checks.

## Interface
- `FILT_CYC`, 2: extra consecutive cycles a new pattern must stay stable before it is accepted. 0 means accept the pattern as soon as it is registered.
- `POS_W`, 16: width of `position`, two's complement, in half-steps.
- `PER_W`, 24: width of the period counter and `step_period`.
- `clk` in 1: system clock; the only clock.
- `resetb` in 1: reset, synchronous and active-low.
- `phases` in 4: coil pattern, same encoding as `pulses_out`, synchronous to `clk`.
- `err_clr` in 1: clears `err_skip` and `err_pat`.
- `step_strobe` out 1: one-cycle pulse per accepted step.
- `step_dir` out 1: direction of the last step; 1 = increasing phase index.
- `step_full` out 1: size of the last step; 1 = full step (±2), 0 = half step (±1).
- `position` out POS_W: signed half-step count.
- `step_period` out PER_W: `clk` cycles between the last two strobes.
- `moving` out 1: set by each strobe; cleared when the period counter saturates.
- `err_skip` out 1: sticky; phase jump of 3, 4 or 5.
- `err_pat` out 1: sticky; a pattern outside the table and not 0000 was accepted.

## Operation
- **Phase table** (index: pattern): 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
  - 0000 = idle (coils off).
  - Any other pattern = illegal.
- **Input path:** `phases` is registered into `ph_q`.
  - Candidate = `ph_q`; a stability counter resets whenever `ph_q` changes.
  - The candidate is accepted when it has been stable for FILT_CYC further cycles and differs from the last accepted pattern.
- **State machine:**
  - NOREF: no reference index.
    - Valid pattern accepted → load `ref_idx`, go to TRACK. No strobe.
    - Idle → stay in NOREF.
    - Illegal → set `err_pat`, stay in NOREF.
  - TRACK: delta = (new_idx − `ref_idx`) mod 8.
    - Delta 1 or 2: forward, `position` += delta.
    - Delta 7 or 6: reverse, `position` −= 1 or 2.
    - Valid steps pulse `step_strobe`, update `step_dir`/`step_full`, set `ref_idx` = new_idx.
    - Delta 3, 4 or 5: set `err_skip`, no strobe, `position` unchanged, `ref_idx` = new_idx (resync).
    - Idle accepted: stay in TRACK and keep `ref_idx`. The motor holds its position with coils off, and the next valid pattern is compared against `ref_idx`.
    - Illegal accepted: set `err_pat`, keep `ref_idx`, no other effect.
- **Arithmetic:**
  - `position` wraps modulo 2^POS_W with no saturation.
  - The period counter increments every cycle and saturates at 2^PER_W−1.
- **Period measurement:**
  - On a strobe, `step_period` ← counter + 1 (saturated), then the counter ← 0.
  - The first strobe after leaving NOREF reports `step_period` = 0.
- **Simultaneous events:** `err_clr` in the same cycle as a new error leaves the flag set.

## Timing
- **Reset:** while `resetb` = 0 at a `clk` edge:
  - state = NOREF; `ph_q` = 0000; last accepted pattern = 0000.
  - All outputs are 0, including `position`, `step_period`, `moving` and both error flags.
  - Period and stability counters are 0.
- **Reset mid-operation:** discards any pending candidate and the reference. The next accepted pattern only reloads the reference.
- **Latency:** the pattern first appears on `phases` before edge N. `ph_q` updates at edge N. Acceptance occurs at edge N+FILT_CYC. `step_strobe`, `position` and flags update at edge N+FILT_CYC+1.
- **Pulse rules:**
  - A strobe is exactly 1 cycle.
  - Back-to-back strobes are possible only when FILT_CYC = 0.
- **Glitch rejection:** a pattern held for FILT_CYC cycles or fewer is never accepted.
- **`moving`:** deasserts in the cycle after the counter reaches 2^PER_W−1.

## Structure
- **Shared `step_motor_pkg`:** the 8 phase constants, IDLE pattern, NOREF/TRACK state encoding, and the delta classification constants (FWD1, FWD2, REV1, REV2, SKIP). The generator side reuses the same table.
- **Sub-module `phase_decode`:** combinational; pattern → {idx[2:0], valid, idle}.
- Filtering, the FSM, the counters and the flags stay in `step_phase_monitor`.

## Test plan
1. Defaults, hold 1000, then 0100, 0010, 0001, 1000 at 100-cycle intervals → 4 strobes with `step_dir`=1 and `step_full`=1. Final `position` = 8. `step_period` = 100 from the second strobe on (first = 0).
2. Hold 1000, then 1001, 0001, 0011 → 3 strobes with `step_dir`=0 and `step_full`=0. `position` = 0xFFFD.
3. 1000 then 0010 (delta 4) → `err_skip`=1, no strobe, `position` unchanged. Then 0001 → strobe at +2. `err_clr` pulse → `err_skip`=0.
4. Hold 1000 with a 2-cycle 0100 glitch (FILT_CYC=2) → no strobe. Hold 1111 → `err_pat`=1, `position` unchanged. Then 1100 → +1 strobe.
5. POS_W=4, PER_W=8: 7 forward half-steps, then one more → `position` wraps 7 → −8. Hold 0000 for 300 cycles → `moving`=0, `step_period` unchanged. Then resume from index 0 with 0100 → +2 strobe.
6. Assert `resetb`=0 mid-filter while changing 1000→0100 → all outputs 0. Next pattern 0010 → reference only, no strobe. Then 0011 → +1 strobe with `step_period`=0.

Source files
------------

// File: rtl/step_motor_pkg.sv
// Shared stepper-motor definitions: the coil phase table, the idle pattern,
// the monitor state encoding and the classification of index jumps.
package step_motor_pkg;

    // Coil patterns for phase indices 0..7 (half-step sequence).
    localparam logic [3:0] PH_0 = 4'b1000;
    localparam logic [3:0] PH_1 = 4'b1100;
    localparam logic [3:0] PH_2 = 4'b0100;
    localparam logic [3:0] PH_3 = 4'b0110;
    localparam logic [3:0] PH_4 = 4'b0010;
    localparam logic [3:0] PH_5 = 4'b0011;
    localparam logic [3:0] PH_6 = 4'b0001;
    localparam logic [3:0] PH_7 = 4'b1001;

    // All coils off.
    localparam logic [3:0] PAT_IDLE = 4'b0000;

    // NOREF: no reference index yet; TRACK: steps are measured against ref_idx.
    typedef enum logic {
        ST_NOREF = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    // Meaning of (new_idx - ref_idx) mod 8.
    typedef enum logic [2:0] {
        DC_NONE = 3'd0,
        DC_FWD1 = 3'd1,
        DC_FWD2 = 3'd2,
        DC_REV1 = 3'd3,
        DC_REV2 = 3'd4,
        DC_SKIP = 3'd5
    } delta_class_e;

    // Decoded view of one coil pattern.
    typedef struct packed {
        logic [2:0] idx;
        logic       valid;
        logic       idle;
    } phase_info_t;

    function automatic delta_class_e classify_delta(input logic [2:0] delta);
        case (delta)
            3'd1:             return DC_FWD1;
            3'd2:             return DC_FWD2;
            3'd7:             return DC_REV1;
            3'd6:             return DC_REV2;
            3'd3, 3'd4, 3'd5: return DC_SKIP;
            default:          return DC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/phase_decode.sv
// Combinational decode of a coil pattern into its phase index, with flags
// telling whether the pattern is in the phase table or is the idle pattern.
module phase_decode
    import step_motor_pkg::*;
(
    input  logic [3:0]  pattern,
    output phase_info_t info
);

    // Table lookup; anything not in the table and not idle leaves both flags low
    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        info = '{idx: 3'd0, valid: 1'b0, idle: 1'b0};
        case (pattern)
            PH_0:     begin info.idx = 3'd0; info.valid = 1'b1; end
            PH_1:     begin info.idx = 3'd1; info.valid = 1'b1; end
            PH_2:     begin info.idx = 3'd2; info.valid = 1'b1; end
            PH_3:     begin info.idx = 3'd3; info.valid = 1'b1; end
            PH_4:     begin info.idx = 3'd4; info.valid = 1'b1; end
            PH_5:     begin info.idx = 3'd5; info.valid = 1'b1; end
            PH_6:     begin info.idx = 3'd6; info.valid = 1'b1; end
            PH_7:     begin info.idx = 3'd7; info.valid = 1'b1; end
            PAT_IDLE: info.idle = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/step_phase_monitor.sv
// Step phase monitor: turns the coil-drive pattern back into step events,
// keeps a signed half-step position, measures the step period and flags
// skipped or illegal patterns.
module step_phase_monitor
    import step_motor_pkg::*;
#(
    parameter int FILT_CYC = 2,
    parameter int POS_W    = 16,
    parameter int PER_W    = 24
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [3:0]       phases,
    input  logic             err_clr,
    output logic             step_strobe,
    output logic             step_dir,
    output logic             step_full,
    output logic [POS_W-1:0] position,
    output logic [PER_W-1:0] step_period,
    output logic             moving,
    output logic             err_skip,
    output logic             err_pat
);

    localparam int                STAB_W    = (FILT_CYC > 0) ? $clog2(FILT_CYC + 1) : 1;
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(FILT_CYC);
    localparam logic [PER_W-1:0]  PER_MAX   = {PER_W{1'b1}};

    logic [3:0]        ph_q;
    logic [3:0]        last_acc;
    logic [STAB_W-1:0] stab_cnt;
    logic              accept;
    phase_info_t       dec;
    logic [2:0]        ref_idx;
    logic [2:0]        delta;
    delta_class_e      dclass;
    state_e            state;
    state_e            state_nxt;
    logic              load_ref;
    logic              do_step;
    logic              set_skip;
    logic              set_pat;
    logic              ev_fwd;
    logic              ev_full;
    logic              first_step;
    logic [PER_W-1:0]  per_cnt;
    logic [POS_W-1:0]  pos_mag;

    // Register the pattern and count how long it has stayed unchanged
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every block sees pre-edge values.
        if (!resetb) begin
            ph_q     <= PAT_IDLE;
            stab_cnt <= '0;
        end else begin
            ph_q <= phases;
            if (phases != ph_q)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_DONE)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // A stable pattern that differs from the last accepted one is a new event
    assign accept = (stab_cnt == STAB_DONE) && (ph_q != last_acc);

    // Remember the last accepted pattern so a held pattern is reported once
    always_ff @(posedge clk) begin
        if (!resetb)
            last_acc <= PAT_IDLE;
        else if (accept)
            last_acc <= ph_q;
    end

    phase_decode u_decode (
        .pattern (ph_q),
        .info    (dec)
    );

    assign delta  = dec.idx - ref_idx;
    assign dclass = classify_delta(delta);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetb)
            state <= ST_NOREF;
        else
            state <= state_nxt;
    end

    // FSM next state: the first accepted valid pattern establishes the reference
    always_comb begin
        state_nxt = state;
        if (state == ST_NOREF && accept && dec.valid)
            state_nxt = ST_TRACK;
    end

    // FSM outputs: classify the accepted pattern into one event for the datapath
    always_comb begin
        load_ref = 1'b0;
        do_step  = 1'b0;
        set_skip = 1'b0;
        set_pat  = 1'b0;
        ev_fwd   = 1'b0;
        ev_full  = 1'b0;
        if (accept) begin
            if (!dec.valid && !dec.idle) begin
                set_pat = 1'b1;
            end else if (dec.valid) begin
                if (state == ST_NOREF) begin
                    load_ref = 1'b1;
                end else begin
                    case (dclass)
                        DC_FWD1: begin do_step = 1'b1; ev_fwd = 1'b1; end
                        DC_FWD2: begin do_step = 1'b1; ev_fwd = 1'b1; ev_full = 1'b1; end
                        DC_REV1: begin do_step = 1'b1; end
                        DC_REV2: begin do_step = 1'b1; ev_full = 1'b1; end
                        DC_SKIP: set_skip = 1'b1;
                        default: ;
                    endcase
                    load_ref = do_step | set_skip;
                end
            end
        end
    end

    // Reference index, and a marker that the next strobe is the first since NOREF
    always_ff @(posedge clk) begin
        if (!resetb) begin
            ref_idx    <= 3'd0;
            first_step <= 1'b0;
        end else begin
            if (load_ref)
                ref_idx <= dec.idx;
            if (load_ref && state == ST_NOREF)
                first_step <= 1'b1;
            else if (do_step)
                first_step <= 1'b0;
        end
    end

    assign pos_mag = ev_full ? POS_W'(2) : POS_W'(1);

    // Step strobe, direction, size and wrapping half-step position
    always_ff @(posedge clk) begin
        if (!resetb) begin
            step_strobe <= 1'b0;
            step_dir    <= 1'b0;
            step_full   <= 1'b0;
            position    <= '0;
        end else begin
            step_strobe <= do_step;
            if (do_step) begin
                step_dir  <= ev_fwd;
                step_full <= ev_full;
                position  <= ev_fwd ? position + pos_mag : position - pos_mag;
            end
        end
    end

    // Saturating period counter, captured period and motion indicator
    always_ff @(posedge clk) begin
        if (!resetb) begin
            per_cnt     <= '0;
            step_period <= '0;
            moving      <= 1'b0;
        end else if (do_step) begin
            per_cnt     <= '0;
            step_period <= first_step ? '0
                         : ((per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1);
            moving      <= 1'b1;
        end else begin
            if (per_cnt != PER_MAX)
                per_cnt <= per_cnt + 1'b1;
            else
                moving <= 1'b0;
        end
    end

    // Sticky error flags; a new error wins over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (!resetb) begin
            err_skip <= 1'b0;
            err_pat  <= 1'b0;
        end else begin
            err_skip <= set_skip | (err_skip & ~err_clr);
            err_pat  <= set_pat  | (err_pat  & ~err_clr);
        end
    end

endmodule

// File: tb/tb_step_phase_monitor.sv
// Self-checking bench for step_phase_monitor: directed scenarios plus a
// randomized pattern stream checked against a behavioural model.
module tb_step_phase_monitor;

    localparam int FILT    = 2;
    localparam int PER_MAX = (1 << 24) - 1;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  phases = 4'b0000;
    logic [3:0]  phases_s = 4'b0000;

    logic        step_strobe, step_dir, step_full, moving, err_skip, err_pat;
    logic [15:0] position;
    logic [23:0] step_period;

    logic        step_strobe_s, step_dir_s, step_full_s, moving_s, err_skip_s, err_pat_s;
    logic [3:0]  position_s;
    logic [7:0]  step_period_s;

    always #5 clk = ~clk;

    step_phase_monitor #(.FILT_CYC(FILT), .POS_W(16), .PER_W(24)) u_dut (
        .clk         (clk),
        .resetb      (resetb),
        .phases      (phases),
        .err_clr     (err_clr),
        .step_strobe (step_strobe),
        .step_dir    (step_dir),
        .step_full   (step_full),
        .position    (position),
        .step_period (step_period),
        .moving      (moving),
        .err_skip    (err_skip),
        .err_pat     (err_pat)
    );

    step_phase_monitor #(.FILT_CYC(FILT), .POS_W(4), .PER_W(8)) u_small (
        .clk         (clk),
        .resetb      (resetb),
        .phases      (phases_s),
        .err_clr     (err_clr),
        .step_strobe (step_strobe_s),
        .step_dir    (step_dir_s),
        .step_full   (step_full_s),
        .position    (position_s),
        .step_period (step_period_s),
        .moving      (moving_s),
        .err_skip    (err_skip_s),
        .err_pat     (err_pat_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int strobe_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (step_strobe) strobe_cnt <= strobe_cnt + 1;

    logic [3:0] table_pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};

    logic [44:0] dut_vec;
    assign dut_vec = {position, step_dir, step_full, err_skip, err_pat, moving, step_period};

    // ---------------- behavioural model ----------------
    int         m_pos, m_period, m_strobes, m_t_prev, m_ref;
    bit         m_dir, m_full, m_skip, m_pat, m_moving, m_tracking, m_have_prev;
    logic [3:0] m_last;

    function automatic int pat_index(input logic [3:0] p);
        for (int i = 0; i < 8; i++)
            if (table_pat[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [44:0] m_vec();
        logic [15:0] pos;
        logic [23:0] per;
        pos = m_pos[15:0];
        per = m_period[23:0];
        return {pos, m_dir, m_full, m_skip, m_pat, m_moving, per};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_period = 0; m_t_prev = 0; m_ref = 0;
        m_dir = 0; m_full = 0; m_skip = 0; m_pat = 0; m_moving = 0;
        m_tracking = 0; m_have_prev = 0; m_last = 4'b0000;
    endtask

    // One accepted pattern, applied at bench cycle t.
    task automatic model_accept(input logic [3:0] p, input int t);
        int idx;
        int d;
        idx = pat_index(p);
        m_last = p;
        if (p == 4'b0000) return;
        if (idx < 0) begin m_pat = 1; return; end
        if (!m_tracking) begin
            m_tracking = 1; m_ref = idx; m_have_prev = 0;
            return;
        end
        d = (idx - m_ref + 8) % 8;
        m_ref = idx;
        if (d == 0) return;
        if (d >= 3 && d <= 5) begin m_skip = 1; return; end
        if (d <= 2) begin m_pos += d; m_dir = 1; m_full = (d == 2); end
        else begin m_pos -= (8 - d); m_dir = 0; m_full = (d == 6); end
        m_period = m_have_prev ? (((t - m_t_prev) > PER_MAX) ? PER_MAX : (t - m_t_prev)) : 0;
        m_t_prev = t;
        m_have_prev = 1;
        m_moving = 1;
        m_strobes++;
    endtask

    // Present a pattern for n cycles; the model sees it only if it survives the filter.
    task automatic drive(input logic [3:0] p, input int n);
        phases = p;
        if (n > FILT && p != m_last) model_accept(p, cyc);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_s(input logic [3:0] p, input int n);
        phases_s = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        phases = 4'b0000; phases_s = 4'b0000; err_clr = 1'b0;
        resetb = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        resetb = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        phases = 4'b0000; resetb = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (dut_vec !== 45'd0 || step_strobe !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %h strobe %b, want 0", dut_vec, step_strobe);
        end
        n_tests++;
        if ({position_s, step_period_s, moving_s, err_skip_s, err_pat_s, step_strobe_s, step_dir_s, step_full_s} !== 18'd0) begin
            n_fail++; $display("FAIL reset_small: pos %h per %h moving %b", position_s, step_period_s, moving_s);
        end
        model_reset();
        resetb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fwd_full();
        int s0;
        do_reset();
        s0 = strobe_cnt;
        drive(4'b1000, 100);
        n_tests++;
        if (strobe_cnt !== s0) begin n_fail++; $display("FAIL fwd_ref_no_strobe: got %0d want %0d", strobe_cnt - s0, 0); end
        drive(4'b0100, 100);
        n_tests++;
        if (step_period !== 24'd0 || position !== 16'd2) begin
            n_fail++; $display("FAIL fwd_first: period %0d pos %0d, want 0 and 2", step_period, position);
        end
        drive(4'b0010, 100);
        drive(4'b0001, 100);
        drive(4'b1000, 100);
        n_tests++;
        if (position !== 16'd8 || step_period !== 24'd100 || step_dir !== 1'b1 || step_full !== 1'b1) begin
            n_fail++; $display("FAIL fwd_final: pos %0d per %0d dir %b full %b, want 8 100 1 1", position, step_period, step_dir, step_full);
        end
        n_tests++;
        if (strobe_cnt - s0 !== 4) begin n_fail++; $display("FAIL fwd_strobes: got %0d want 4", strobe_cnt - s0); end
        n_tests++;
        if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL fwd_model: got %h want %h", dut_vec, m_vec()); end
    endtask

    task automatic test_rev_half();
        int s0;
        do_reset();
        s0 = strobe_cnt;
        drive(4'b1000, 20);
        drive(4'b1001, 20);
        drive(4'b0001, 20);
        drive(4'b0011, 20);
        n_tests++;
        if (position !== 16'hFFFD || step_dir !== 1'b0 || step_full !== 1'b0) begin
            n_fail++; $display("FAIL rev_final: pos %h dir %b full %b, want fffd 0 0", position, step_dir, step_full);
        end
        n_tests++;
        if (strobe_cnt - s0 !== 3) begin n_fail++; $display("FAIL rev_strobes: got %0d want 3", strobe_cnt - s0); end
    endtask

    task automatic test_skip();
        int s0;
        do_reset();
        s0 = strobe_cnt;
        drive(4'b1000, 20);
        drive(4'b0010, 20);
        n_tests++;
        if (err_skip !== 1'b1 || position !== 16'd0 || strobe_cnt !== s0) begin
            n_fail++; $display("FAIL skip_flag: err_skip %b pos %0d strobes %0d, want 1 0 0", err_skip, position, strobe_cnt - s0);
        end
        drive(4'b0001, 20);
        n_tests++;
        if (position !== 16'd2 || strobe_cnt - s0 !== 1) begin
            n_fail++; $display("FAIL skip_resync: pos %0d strobes %0d, want 2 1", position, strobe_cnt - s0);
        end
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
        m_skip = 0; m_pat = 0;
        n_tests++;
        if (err_skip !== 1'b0) begin n_fail++; $display("FAIL skip_clear: got %b want 0", err_skip); end
    endtask

    task automatic test_glitch_illegal();
        int s0;
        do_reset();
        s0 = strobe_cnt;
        drive(4'b1000, 20);
        drive(4'b0100, FILT);
        drive(4'b1000, 20);
        n_tests++;
        if (strobe_cnt !== s0 || position !== 16'd0) begin
            n_fail++; $display("FAIL glitch_reject: strobes %0d pos %0d, want 0 0", strobe_cnt - s0, position);
        end
        drive(4'b1111, 20);
        n_tests++;
        if (err_pat !== 1'b1 || position !== 16'd0) begin
            n_fail++; $display("FAIL illegal_flag: err_pat %b pos %0d, want 1 0", err_pat, position);
        end
        drive(4'b1100, 20);
        n_tests++;
        if (position !== 16'd1 || strobe_cnt - s0 !== 1) begin
            n_fail++; $display("FAIL illegal_then_step: pos %0d strobes %0d, want 1 1", position, strobe_cnt - s0);
        end
    endtask

    task automatic test_wrap_idle();
        logic [3:0] seq [8] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010,
                                4'b0011, 4'b0001, 4'b1001, 4'b1000};
        do_reset();
        drive_s(4'b1000, 20);
        for (int i = 0; i < 7; i++) drive_s(seq[i], 20);
        n_tests++;
        if (position_s !== 4'd7) begin n_fail++; $display("FAIL wrap_pre: got %0d want 7", position_s); end
        drive_s(seq[7], 20);
        n_tests++;
        if (position_s !== 4'b1000 || step_period_s !== 8'd20 || step_dir_s !== 1'b1) begin
            n_fail++; $display("FAIL wrap_neg8: pos %h per %0d dir %b, want 8 20 1", position_s, step_period_s, step_dir_s);
        end
        drive_s(4'b0000, 300);
        n_tests++;
        if (moving_s !== 1'b0 || step_period_s !== 8'd20) begin
            n_fail++; $display("FAIL idle_stop: moving %b per %0d, want 0 20", moving_s, step_period_s);
        end
        drive_s(4'b0100, 10);
        n_tests++;
        if (position_s !== 4'b1010 || step_period_s !== 8'hFF || moving_s !== 1'b1 || step_full_s !== 1'b1) begin
            n_fail++; $display("FAIL idle_resume: pos %h per %h moving %b full %b, want a ff 1 1", position_s, step_period_s, moving_s, step_full_s);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        do_reset();
        drive(4'b1000, 10);
        drive(4'b1100, 10);
        phases = 4'b0100;
        @(negedge clk);
        resetb = 1'b0;
        phases = 4'b0010;
        repeat (2) @(negedge clk);
        n_tests++;
        if (dut_vec !== 45'd0 || step_strobe !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h, want 0", dut_vec);
        end
        model_reset();
        resetb = 1'b1;
        s0 = strobe_cnt;
        drive(4'b0010, 10);
        n_tests++;
        if (strobe_cnt !== s0 || position !== 16'd0) begin
            n_fail++; $display("FAIL midreset_ref: strobes %0d pos %0d, want 0 0", strobe_cnt - s0, position);
        end
        drive(4'b0011, 10);
        n_tests++;
        if (position !== 16'd1 || step_period !== 24'd0 || strobe_cnt - s0 !== 1) begin
            n_fail++; $display("FAIL midreset_step: pos %0d per %0d strobes %0d, want 1 0 1", position, step_period, strobe_cnt - s0);
        end
    endtask

    task automatic test_random();
        int         cur;
        int         sel;
        int         steps [4] = '{1, 2, 6, 7};
        logic [3:0] p;
        logic [3:0] g;
        do_reset();
        cur = 0;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                cur = (cur + steps[$urandom_range(0, 3)]) % 8;
                p = table_pat[cur];
            end else if (sel == 6) begin
                cur = (cur + $urandom_range(3, 5)) % 8;
                p = table_pat[cur];
            end else if (sel == 7) begin
                p = 4'b0000;
            end else if (sel == 8) begin
                p = 4'($urandom_range(1, 15));
                while (pat_index(p) >= 0) p = 4'($urandom_range(1, 15));
            end else begin
                p = table_pat[cur];
            end
            if ($urandom_range(0, 3) == 0) begin
                g = 4'($urandom_range(0, 15));
                while (g == p) g = 4'($urandom_range(0, 15));
                drive(g, $urandom_range(1, FILT));
            end
            drive(p, $urandom_range(FILT + 2, 40));
            n_tests++;
            if (dut_vec !== m_vec()) begin
                n_fail++; $display("FAIL random_state[%0d]: got %h want %h (pattern %b)", i, dut_vec, m_vec(), p);
            end
            n_tests++;
            if (strobe_cnt !== m_strobes) begin
                n_fail++; $display("FAIL random_strobes[%0d]: got %0d want %0d", i, strobe_cnt, m_strobes);
            end
            if ($urandom_range(0, 5) == 0) begin
                err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
                m_skip = 0; m_pat = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_strobes = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        m_strobes = strobe_cnt;
        test_fwd_full();
        test_rev_half();
        test_skip();
        test_glitch_illegal();
        test_wrap_idle();
        test_reset_mid();
        m_strobes = strobe_cnt;
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
